// File: rtl/prog_loader_if.sv
// Byte-stream source and unified memory port seen by the program loader.
// master = loader side, slave = stream source plus memory.
interface prog_loader_if;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  logic [DW-1:0] i_s_data;
  logic          i_s_valid;
  logic          o_s_ready;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_data_write;
  logic          o_mem_write_enable;
  logic [DW-1:0] i_mem_data_read;

  modport master (
    input  i_s_data, i_s_valid, i_mem_data_read,
    output o_s_ready, o_mem_addr, o_mem_data_write, o_mem_write_enable
  );

  modport slave (
    output i_s_data, i_s_valid, i_mem_data_read,
    input  o_s_ready, o_mem_addr, o_mem_data_write, o_mem_write_enable
  );
endinterface

// File: rtl/prog_loader.sv
// Streams a program image into memory while holding the CPU in reset,
// then optionally reads it back and compares checksums.
module prog_loader #(
  parameter int unsigned READ_LATENCY = 1,
  parameter bit          VERIFY       = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic [7:0]    i_base_addr,
  input  logic [8:0]    i_len,
  prog_loader_if.master bus,
  output logic          o_busy,
  output logic          o_cpu_rstn,
  output logic          o_done,
  output logic          o_error,
  output logic [7:0]    o_checksum
);
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 9;
  localparam logic [LW-1:0] MAX_LEN = LW'(256);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_VERIFY, ST_DONE} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           base_q, base_d;
  logic [LW-1:0]           len_q, len_d;
  logic [LW-1:0]           wcnt_q, wcnt_d;
  logic [LW-1:0]           icnt_q, icnt_d;
  logic [LW-1:0]           rcnt_q, rcnt_d;
  logic [DW-1:0]           wsum_q, wsum_d;
  logic [DW-1:0]           rsum_q, rsum_d;
  logic                    av_q, av_d;
  logic [READ_LATENCY-1:0] tag_q, tag_d;
  logic                    ready_q, ready_d;
  logic                    we_q, we_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [DW-1:0]           wdata_q, wdata_d;
  logic                    busy_q, busy_d;
  logic                    cpu_rstn_q, cpu_rstn_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [DW-1:0]           checksum_q, checksum_d;

  logic          hs;
  logic          rd_ret;
  logic [DW-1:0] rd_sum;
  logic          finish;
  logic          fin_err;

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      wcnt_q     <= '0;
      icnt_q     <= '0;
      rcnt_q     <= '0;
      wsum_q     <= '0;
      rsum_q     <= '0;
      av_q       <= 1'b0;
      tag_q      <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      cpu_rstn_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      icnt_q     <= icnt_d;
      rcnt_q     <= rcnt_d;
      wsum_q     <= wsum_d;
      rsum_q     <= rsum_d;
      av_q       <= av_d;
      tag_q      <= tag_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      cpu_rstn_q <= cpu_rstn_d;
      done_q     <= done_d;
      error_q    <= error_d;
      checksum_q <= checksum_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    icnt_d     = icnt_q;
    rcnt_d     = rcnt_q;
    wsum_d     = wsum_q;
    rsum_d     = rsum_q;
    av_d       = 1'b0;
    ready_d    = 1'b0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    cpu_rstn_d = cpu_rstn_q;
    done_d     = 1'b0;
    error_d    = error_q;
    checksum_d = checksum_q;
    finish     = 1'b0;
    fin_err    = 1'b0;

    hs     = (state_q == ST_WRITE) && bus.i_s_valid && ready_q;
    rd_ret = tag_q[READ_LATENCY-1];
    rd_sum = rsum_q + bus.i_mem_data_read;

    // Valid tags travel alongside the memory read pipeline
    tag_d[0] = av_q;
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d    = ST_WRITE;
          base_d     = i_base_addr;
          len_d      = (i_len > MAX_LEN) ? MAX_LEN : i_len;
          wcnt_d     = '0;
          icnt_d     = '0;
          rcnt_d     = '0;
          wsum_d     = '0;
          rsum_d     = '0;
          error_d    = 1'b0;
          checksum_d = '0;
          busy_d     = 1'b1;
          cpu_rstn_d = 1'b0;
        end
      end
      ST_WRITE: begin
        if (hs) begin
          addr_d  = base_q + wcnt_q[AW-1:0];
          wdata_d = bus.i_s_data;
          we_d    = 1'b1;
          wsum_d  = wsum_q + bus.i_s_data;
          wcnt_d  = wcnt_q + LW'(1);
        end
        ready_d = (wcnt_d < len_q);
        // A zero-length load also passes through here so DONE lands one cycle after start
        if (wcnt_q == len_q) begin
          if (VERIFY && (len_q != '0)) begin
            state_d = ST_VERIFY;
            addr_d  = base_q;
            av_d    = 1'b1;
            icnt_d  = LW'(1);
          end else begin
            finish = 1'b1;
          end
        end
      end
      ST_VERIFY: begin
        if (icnt_q < len_q) begin
          addr_d = base_q + icnt_q[AW-1:0];
          av_d   = 1'b1;
          icnt_d = icnt_q + LW'(1);
        end
        if (rd_ret) begin
          rsum_d = rd_sum;
          rcnt_d = rcnt_q + LW'(1);
          if ((rcnt_q + LW'(1)) == len_q) begin
            finish  = 1'b1;
            fin_err = (rd_sum != wsum_q);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (finish) begin
      state_d    = ST_DONE;
      done_d     = 1'b1;
      busy_d     = 1'b0;
      cpu_rstn_d = 1'b1;
      checksum_d = wsum_q;
      error_d    = fin_err;
    end
  end

  assign bus.o_s_ready          = ready_q;
  assign bus.o_mem_addr         = addr_q;
  assign bus.o_mem_data_write   = wdata_q;
  assign bus.o_mem_write_enable = we_q;
  assign o_busy                 = busy_q;
  assign o_cpu_rstn             = cpu_rstn_q;
  assign o_done                 = done_q;
  assign o_error                = error_q;
  assign o_checksum             = checksum_q;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: memory model with optional read corruption, and a
// reference of expected writes, sums and done timing built from the load parameters.
module tb_prog_loader;
  localparam int unsigned RL = 2;

  logic       clk;
  logic       i_rstn;
  logic       i_start;
  logic [7:0] i_base_addr;
  logic [8:0] i_len;
  logic       o_busy, o_cpu_rstn, o_done, o_error;
  logic [7:0] o_checksum;

  prog_loader_if bus ();

  prog_loader #(.READ_LATENCY(RL), .VERIFY(1'b1)) dut (
    .i_clk       (clk),
    .i_rstn      (i_rstn),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_len       (i_len),
    .bus         (bus),
    .o_busy      (o_busy),
    .o_cpu_rstn  (o_cpu_rstn),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_checksum  (o_checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory model: synchronous write, RL-stage read pipeline
  logic [7:0] mem   [256];
  logic [7:0] rpipe [RL];
  bit         corrupt_en = 1'b0;
  logic [7:0] corrupt_addr = 8'h00;

  always @(posedge clk) begin
    if (bus.o_mem_write_enable) mem[bus.o_mem_addr] <= bus.o_mem_data_write;
    rpipe[0] <= (corrupt_en && bus.o_mem_addr == corrupt_addr) ? (mem[bus.o_mem_addr] ^ 8'hFF)
                                                               : mem[bus.o_mem_addr];
    for (int i = 1; i < int'(RL); i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.i_mem_data_read = rpipe[RL-1];

  // Monitor (written only here; the main sequence takes snapshots)
  int         cyc_n = 0, n_done = 0, n_ready = 0, n_hs = 0, n_sv = 0, n_cv = 0, wr_cnt = 0;
  int         busy_rise = 0, done_at = 0;
  logic [15:0] wr_log [2048];
  logic [7:0] chk_at_done;
  logic       err_at_done, busy_at_done, cpu_at_done, err_at_start;
  bit         hs_prev = 1'b0, busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc_n++;
    if (!i_rstn) begin
      hs_prev   = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (bus.o_mem_write_enable) begin
        if (wr_cnt < 2048) wr_log[wr_cnt] = {bus.o_mem_addr, bus.o_mem_data_write};
        wr_cnt++;
      end
      if (bus.o_mem_write_enable !== hs_prev) n_sv++;
      hs_prev = bus.i_s_valid && bus.o_s_ready;
      if (bus.o_s_ready) n_ready++;
      if (bus.i_s_valid && bus.o_s_ready) n_hs++;
      if (o_cpu_rstn !== !o_busy) n_cv++;
      if (o_busy && !busy_prev) begin
        busy_rise    = cyc_n;
        err_at_start = o_error;
      end
      busy_prev = o_busy;
      if (o_done) begin
        n_done++;
        done_at      = cyc_n;
        chk_at_done  = o_checksum;
        err_at_done  = o_error;
        busy_at_done = o_busy;
        cpu_at_done  = o_cpu_rstn;
      end
    end
  end

  // Reference state
  logic [7:0] src [300];
  int         nsrc;
  logic [7:0] ref_mem [256];
  bit         ref_valid [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/s_ready"},  32'(bus.o_s_ready),          32'(0));
    check({tag, "/we"},       32'(bus.o_mem_write_enable), 32'(0));
    check({tag, "/addr"},     32'(bus.o_mem_addr),         32'(0));
    check({tag, "/wdata"},    32'(bus.o_mem_data_write),   32'(0));
    check({tag, "/busy"},     32'(o_busy),                 32'(0));
    check({tag, "/cpu_rstn"}, 32'(o_cpu_rstn),             32'(1));
    check({tag, "/done"},     32'(o_done),                 32'(0));
    check({tag, "/error"},    32'(o_error),                32'(0));
    check({tag, "/checksum"}, 32'(o_checksum),             32'(0));
  endtask

  task automatic fill_src(input int n);
    nsrc = n;
    for (int i = 0; i < n; i++) src[i] = 8'($urandom);
  endtask

  // mode: 0 continuous valid, 1 valid every other cycle, 2 random valid
  task automatic run_load(input string tag, input logic [7:0] base, input logic [8:0] len_in,
                          input int mode, input bit mid_start);
    int         eff, idx, cyc, mm;
    int         w0, d0, r0, h0, s0, c0;
    logic [7:0] wsum, rsum, a, d;
    logic       exp_err, rdy;

    eff  = (len_in > 9'd256) ? 256 : int'(len_in);
    wsum = 8'h00;
    rsum = 8'h00;
    for (int i = 0; i < eff; i++) begin
      a = 8'(int'(base) + i);
      wsum = wsum + src[i];
      ref_mem[a]   = src[i];
      ref_valid[a] = 1'b1;
    end
    for (int i = 0; i < eff; i++) begin
      a = 8'(int'(base) + i);
      d = (corrupt_en && a == corrupt_addr) ? (ref_mem[a] ^ 8'hFF) : ref_mem[a];
      rsum = rsum + d;
    end
    exp_err = (rsum != wsum);

    w0 = wr_cnt; d0 = n_done; r0 = n_ready; h0 = n_hs; s0 = n_sv; c0 = n_cv;

    @(posedge clk); #1;
    i_start = 1'b1; i_base_addr = base; i_len = len_in;
    @(posedge clk); #1;
    i_start = 1'b0; i_base_addr = 8'($urandom); i_len = 9'($urandom);
    idx = 0;
    cyc = 0;
    while (n_done == d0 && cyc < 3000) begin
      case (mode)
        0:       bus.i_s_valid = (idx < nsrc);
        1:       bus.i_s_valid = cyc[0] && (idx < nsrc);
        default: bus.i_s_valid = ($urandom_range(0, 3) != 0) && (idx < nsrc);
      endcase
      bus.i_s_data = (idx < nsrc) ? src[idx] : 8'($urandom);
      i_start = (mid_start && (cyc == 2 || cyc == 5));
      @(negedge clk); rdy = bus.o_s_ready;
      @(posedge clk); #1;
      if (bus.i_s_valid && rdy) idx++;
      cyc++;
    end
    bus.i_s_valid = 1'b0;
    i_start = 1'b0;
    @(negedge clk);

    check({tag, "/done_pulses"}, 32'(n_done - d0), 32'(1));
    check({tag, "/checksum"},    32'(chk_at_done), 32'(wsum));
    check({tag, "/error"},       32'(err_at_done), 32'(exp_err));
    check({tag, "/busy_at_done"}, 32'(busy_at_done), 32'(0));
    check({tag, "/cpu_at_done"},  32'(cpu_at_done), 32'(1));
    check({tag, "/err_clr_on_start"}, 32'(err_at_start), 32'(0));
    check({tag, "/handshakes"},  32'(n_hs - h0), 32'(eff));
    check({tag, "/strobes"},     32'(wr_cnt - w0), 32'(eff));
    check({tag, "/strobe_vs_hs"}, 32'(n_sv - s0), 32'(0));
    check({tag, "/cpu_rstn_vs_busy"}, 32'(n_cv - c0), 32'(0));
    mm = 0;
    for (int i = 0; i < eff && (w0 + i) < 2048; i++)
      if (wr_log[w0 + i] !== {8'(int'(base) + i), src[i]}) mm++;
    check({tag, "/write_seq"}, 32'(mm), 32'(0));
    mm = 0;
    for (int i = 0; i < 256; i++)
      if (ref_valid[i] && mem[i] !== ref_mem[i]) mm++;
    check({tag, "/mem"}, 32'(mm), 32'(0));
    if (mode == 0 || eff == 0)
      check({tag, "/latency"}, 32'(done_at - busy_rise), 32'((eff == 0) ? 1 : 2 * eff + int'(RL) + 2));
    if (mode == 0)
      check({tag, "/ready_cycles"}, 32'(n_ready - r0), 32'(eff));
  endtask

  initial begin
    int idx;
    int cyc;
    logic rdy;

    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = 8'h00;
      ref_valid[i] = 1'b0;
    end
    i_rstn = 1'b0; i_start = 1'b0; i_base_addr = 8'h00; i_len = 9'd0;
    bus.i_s_valid = 1'b0; bus.i_s_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    #1 i_rstn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("post_reset");

    nsrc = 4;
    src[0] = 8'h01; src[1] = 8'h02; src[2] = 8'h03; src[3] = 8'h04;
    run_load("basic", 8'h10, 9'd4, 0, 1'b0);
    check("basic/checksum_0a", 32'(o_checksum), 32'h0A);
    run_load("toggle", 8'h10, 9'd4, 1, 1'b0);

    nsrc = 3;
    src[0] = 8'hAA; src[1] = 8'hBB; src[2] = 8'hCC;
    run_load("wrap", 8'hFE, 9'd3, 0, 1'b0);
    check("wrap/checksum_31", 32'(o_checksum), 32'h31);

    nsrc = 4;
    src[0] = 8'h01; src[1] = 8'h02; src[2] = 8'h03; src[3] = 8'h04;
    corrupt_en = 1'b1; corrupt_addr = 8'h11;
    run_load("corrupt", 8'h10, 9'd4, 0, 1'b0);
    corrupt_en = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("corrupt/sticky", 32'(o_error), 32'(1));

    run_load("len0", 8'h20, 9'd0, 0, 1'b0);
    check("len0/error_cleared", 32'(o_error), 32'(0));

    fill_src(300);
    run_load("len300", 8'h80, 9'd300, 0, 1'b0);

    // Reset after two of four bytes have landed in memory
    fill_src(4);
    @(posedge clk); #1;
    i_start = 1'b1; i_base_addr = 8'h40; i_len = 9'd4;
    @(posedge clk); #1;
    i_start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 2 && cyc < 50) begin
      bus.i_s_valid = 1'b1;
      bus.i_s_data  = src[idx];
      @(negedge clk); rdy = bus.o_s_ready;
      @(posedge clk); #1;
      if (rdy) idx++;
      cyc++;
    end
    bus.i_s_valid = 1'b0;
    check("midreset/accepted", 32'(idx), 32'(2));
    @(posedge clk); #1;
    i_rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    check_reset_outputs("midreset_held");
    for (int i = 0; i < 2; i++) begin
      ref_mem[8'(8'h40 + i)]   = src[i];
      ref_valid[8'(8'h40 + i)] = 1'b1;
    end
    check("midreset/mem0", 32'(mem[8'h40]), 32'(src[0]));
    check("midreset/mem1", 32'(mem[8'h41]), 32'(src[1]));
    #2 i_rstn = 1'b1;
    fill_src(4);
    run_load("after_reset", 8'h50, 9'd4, 0, 1'b0);

    fill_src(8);
    run_load("mid_start", 8'h60, 9'd8, 0, 1'b1);

    for (int t = 0; t < 4; t++) begin
      fill_src(64);
      corrupt_en   = ($urandom_range(0, 1) == 1);
      corrupt_addr = 8'($urandom);
      run_load($sformatf("rand%0d", t), 8'($urandom), 9'($urandom_range(1, 64)), 2, 1'b0);
      corrupt_en = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
